// File: rtl/counter_pkg.sv
// Shared types and constants for the BCD countdown counter family.
package counter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_dec.sv
// Combinational single-decade BCD decrement with borrow chaining.
module bcd_digit_dec
  import counter_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] digit_next,
  output logic               borrow_out
);

  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == '0) begin
        digit_next = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/cascade_bcd_countdown.sv
// Multi-decade BCD down counter with programmable start, one-shot or auto-reload,
// and a one-cycle terminal-count pulse.
module cascade_bcd_countdown
  import counter_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic                      Enable,
  input  logic                      Load,
  input  logic [DIGIT_W*DIGITS-1:0] LoadValue,
  input  logic                      AutoReload,
  output logic [DIGIT_W*DIGITS-1:0] Count,
  output logic                      Tc,
  output logic                      Busy,
  output logic                      Done
);

  localparam int unsigned W = DIGIT_W * DIGITS;
  localparam logic [W-1:0] CountOne = W'(1);

  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[i*DIGIT_W +: DIGIT_W] = (v[i*DIGIT_W +: DIGIT_W] > BCD_MAX) ?
                                BCD_MAX : v[i*DIGIT_W +: DIGIT_W];
    end
    return r;
  endfunction

  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] reload_q, reload_d;
  logic         tc_q, tc_d;

  logic [W-1:0]    count_dec;
  logic [DIGITS:0] borrow;
  logic [W-1:0]    load_clamped;
  logic            is_zero, is_one, dec_wrap;

  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
    bcd_digit_dec u_dec (
      .digit      (count_q[g*DIGIT_W +: DIGIT_W]),
      .borrow_in  (borrow[g]),
      .digit_next (count_dec[g*DIGIT_W +: DIGIT_W]),
      .borrow_out (borrow[g+1])
    );
  end

  assign load_clamped = clamp_bcd(LoadValue);
  assign is_zero      = (count_q == '0);
  assign is_one       = (count_q == CountOne);
  // A borrow out of the top decade can only come from an all-zero count.
  assign dec_wrap     = borrow[DIGITS];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (Load) begin
      count_d  = load_clamped;
      reload_d = load_clamped;
      state_d  = (load_clamped != '0) ? StRun : StIdle;
    end else begin
      case (state_q)
        StIdle: ;
        StRun: begin
          if (Enable) begin
            if (is_one) begin
              count_d = '0;
              tc_d    = 1'b1;
              if (!AutoReload) state_d = StDone;
            end else if (is_zero || dec_wrap) begin
              // Zero in RUN is the one-cycle gap of an auto-reload period.
              if (AutoReload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = StDone;
              end
            end else begin
              count_d = count_dec;
            end
          end
        end
        StDone: count_d = '0;
        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign Count = count_q;
  assign Tc    = tc_q;
  assign Busy  = (state_q == StRun);
  assign Done  = (state_q == StDone);

endmodule

// File: tb/tb_cascade_bcd_countdown.sv
// Directed self-checking bench for cascade_bcd_countdown with three decades.
module tb_cascade_bcd_countdown;

  localparam int unsigned Digits = 3;
  localparam int unsigned W = 4 * Digits;

  logic         clk;
  logic         n_reset;
  logic         enable;
  logic         load;
  logic [W-1:0] load_value;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;
  logic         done;

  int checks_q;
  int failures_q;

  cascade_bcd_countdown #(
    .DIGITS (Digits)
  ) u_dut (
    .Clk        (clk),
    .nReset     (n_reset),
    .Enable     (enable),
    .Load       (load),
    .LoadValue  (load_value),
    .AutoReload (auto_reload),
    .Count      (count),
    .Tc         (tc),
    .Busy       (busy),
    .Done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_q++;
    if (obs !== exp) begin
      failures_q++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    t = v;
    for (int i = 0; i < int'(Digits); i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  int tc_seen;
  int ar_seq[8];

  initial begin
    checks_q    = 0;
    failures_q  = 0;
    n_reset     = 1'b0;
    enable      = 1'b0;
    load        = 1'b1;
    load_value  = 12'h123;
    auto_reload = 1'b0;

    // Reset dominates a simultaneous load.
    tick();
    tick();
    check_eq("rst_count", 32'(count), 32'h000);
    check_eq("rst_tc", 32'(tc), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);

    // Load then pause.
    n_reset    = 1'b1;
    load_value = 12'h005;
    tick();
    load = 1'b0;
    check_eq("load5_count", 32'(count), 32'h005);
    check_eq("load5_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("pause_count", 32'(count), 32'h005);
      check_eq("pause_tc", 32'(tc), 32'd0);
    end
    check_eq("pause_busy", 32'(busy), 32'd1);

    // One-shot from 12; Enable high during the load cycle must not decrement.
    load       = 1'b1;
    load_value = 12'h012;
    enable     = 1'b1;
    tick();
    load = 1'b0;
    check_eq("os_load", 32'(count), 32'h012);
    for (int v = 11; v >= 0; v--) begin
      tick();
      check_eq("os_count", 32'(count), 32'(to_bcd(v)));
      check_eq("os_tc", 32'(tc), (v == 0) ? 32'd1 : 32'd0);
      check_eq("os_done", 32'(done), (v == 0) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("done_count", 32'(count), 32'h000);
      check_eq("done_tc", 32'(tc), 32'd0);
      check_eq("done_flag", 32'(done), 32'd1);
    end

    // Borrow cascade across decades; Load also leaves DONE.
    load       = 1'b1;
    load_value = 12'h100;
    tick();
    check_eq("leave_done", 32'(done), 32'd0);
    load = 1'b0;
    tick();
    check_eq("borrow_100", 32'(count), 32'h099);
    load       = 1'b1;
    load_value = 12'h010;
    tick();
    load = 1'b0;
    tick();
    check_eq("borrow_010", 32'(count), 32'h009);

    // Auto-reload period of Reload+1 enabled cycles.
    load        = 1'b1;
    load_value  = 12'h003;
    auto_reload = 1'b1;
    tick();
    load = 1'b0;
    check_eq("ar_load", 32'(count), 32'h003);
    ar_seq  = '{2, 1, 0, 3, 2, 1, 0, 3};
    tc_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("ar_count", 32'(count), 32'(to_bcd(ar_seq[i])));
      check_eq("ar_tc", 32'(tc), (ar_seq[i] == 0) ? 32'd1 : 32'd0);
      if (tc) tc_seen++;
    end
    check_eq("ar_tc_total", 32'(tc_seen), 32'd2);
    check_eq("ar_busy", 32'(busy), 32'd1);

    // AutoReload cleared while sitting at zero ends the run.
    load       = 1'b1;
    load_value = 12'h002;
    tick();
    load = 1'b0;
    tick();
    tick();
    check_eq("arclr_tc", 32'(tc), 32'd1);
    auto_reload = 1'b0;
    tick();
    check_eq("arclr_count", 32'(count), 32'h000);
    check_eq("arclr_done", 32'(done), 32'd1);

    // Clamp and zero load.
    load       = 1'b1;
    load_value = 12'hA5F;
    tick();
    check_eq("clamp", 32'(count), 32'h959);
    load_value = 12'h000;
    tick();
    load = 1'b0;
    check_eq("zero_busy", 32'(busy), 32'd0);
    check_eq("zero_done", 32'(done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("zero_tc", 32'(tc), 32'd0);
      check_eq("zero_count", 32'(count), 32'h000);
    end

    // Reload mid-run.
    load       = 1'b1;
    load_value = 12'h047;
    tick();
    load = 1'b0;
    tick();
    check_eq("mid_dec", 32'(count), 32'h046);
    load       = 1'b1;
    load_value = 12'h200;
    tick();
    load = 1'b0;
    check_eq("mid_load", 32'(count), 32'h200);
    tick();
    check_eq("mid_next", 32'(count), 32'h199);

    // Reset during a run, then reset against a load.
    n_reset = 1'b0;
    tick();
    check_eq("mrst_count", 32'(count), 32'h000);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    n_reset    = 1'b1;
    load       = 1'b1;
    load_value = 12'h300;
    tick();
    check_eq("pre_rl", 32'(count), 32'h300);
    n_reset    = 1'b0;
    load_value = 12'h456;
    tick();
    check_eq("rl_count", 32'(count), 32'h000);
    check_eq("rl_busy", 32'(busy), 32'd0);
    n_reset = 1'b1;
    load    = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
    $finish;
  end

endmodule
